multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- FSM sequencer for a multi-cycle RV32I core built from the existing single-cycle datapath pieces: PC, IR, register file, ALU, and a shared single-port instruction/data memory.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the same mux and enable controls as the single-cycle decoder, plus PC/IR enables and a request/ready memory handshake.
- Flags illegal opcodes with a sticky trap.

Parameters:
- AW, 32, address width (pass-through only; no internal use beyond documentation).
- DW, 32, data width (pass-through only).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  7  IR[6:0]; stable from DECODE until instruction retire.
- func3  input  3  IR[14:12].
- func7  input  7  IR[31:25].
- mem_ready  input  1  memory has accepted a write or returned read data this cycle.
- branch_taken  input  1  comparator result for current branch (func3 evaluated externally).
- mem_req  output  1  memory access request; held until mem_ready.
- mem_we  output  1  write strobe; valid only with mem_req.
- mem_addr_sel  output  1  0=PC (fetch), 1=ALU result (data).
- ir_en  output  1  load IR from memory read data.
- pc_en  output  1  update PC this cycle.
- pc_sel  output  1  0=PC+4, 1=ALU result.
- rf_en  output  1  register-file write enable.
- rd_data_sel  output  2  0=none, 1=ALU, 2=memory data, 3=PC+4.
- alu_sel  output  4  ALU operation code.
- rs1_pc_sel  output  1  ALU A: 0=rs1, 1=PC.
- rs2_imm_sel  output  1  ALU B: 0=rs2, 1=imm.
- trap  output  1  illegal instruction; sticky until rst.
- state_o  output  3  current state, for debug/verification.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Register only the state; all outputs are combinational from state, opcode, func3, func7 and branch_taken.
- Reset:
  - While rst=1, every output is 0 and state_o=0.
  - The first cycle after release is FETCH.
  - rst in any state, including a pending MEM handshake, aborts the access immediately: mem_req=0 the same cycle rst is sampled, and state returns to FETCH.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready=1: ir_en=1 for that cycle, next state DECODE.
- DECODE:
  - Exactly one cycle.
  - Legal opcodes: 0110011 (OP), 0010011 (OP-IMM), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 1101111 (JAL), 1100111 (JALR), 0110111 (LUI), 0010111 (AUIPC).
  - Any other opcode goes to TRAP; otherwise EXEC.
- ALU codes:
  - 0=none, 1=add, 2=sub, 3=sll, 4=slt, 5=sltu, 6=xor, 7=srl, 8=sra, 9=or, 10=and, 11=passB.
  - OP/OP-IMM map func3 0..7 to add, sll, slt, sltu, xor, srl, or, and.
  - func3=0 with func7[5]=1 on OP only selects sub.
  - func3=5 with func7[5]=1 selects sra.
  - LOAD, STORE, BRANCH, JAL, JALR, AUIPC use add; LUI uses passB.
- EXEC (one cycle):
  - OP: rs1_pc_sel=0, rs2_imm_sel=0.
  - OP-IMM/LOAD/STORE/JALR: rs1_pc_sel=0, rs2_imm_sel=1.
  - BRANCH/JAL/AUIPC: rs1_pc_sel=1, rs2_imm_sel=1.
  - LUI: rs2_imm_sel=1.
  - BRANCH: pc_en=1, pc_sel=branch_taken, next state FETCH.
  - LOAD/STORE: next state MEM.
  - All others: next state WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only.
  - Hold ALU controls as in EXEC.
  - Stay in MEM while mem_ready=0.
  - On mem_ready=1, STORE asserts pc_en=1, pc_sel=0 and goes to FETCH; LOAD goes to WB.
- WB (one cycle):
  - rf_en=1, pc_en=1.
  - rd_data_sel: 2 for LOAD, 3 for JAL/JALR, 1 otherwise.
  - pc_sel=1 for JAL/JALR, 0 otherwise.
  - Re-drive the EXEC ALU controls for JAL/JALR so the PC target is the ALU output.
  - Next state FETCH.
- TRAP: trap=1 and all other outputs 0; remain in TRAP until rst.
- Invariants (asserted in bench):
  - Never rf_en and mem_we in the same cycle.
  - pc_en at most once per instruction.
  - mem_req never asserted in DECODE, EXEC or WB.
- Latency with mem_ready tied high:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - Each wait cycle adds one cycle.

Test Plan:
- addi (opcode 0010011, func3 0), mem_ready=1 → states 0,1,2,4; alu_sel=1, rs2_imm_sel=1 in EXEC; WB shows rf_en=1, rd_data_sel=1, pc_en=1, pc_sel=0; total 4 cycles.
- sub (0110011, func3 0, func7 0100000) and sra (func3 5) → EXEC alu_sel=2 and 8 respectively, rs2_imm_sel=0; same OP-IMM func7 on func3 0 → alu_sel=1.
- lw with 2 fetch wait cycles and 3 data wait cycles → FETCH held 3 cycles with mem_req=1; MEM held 4 cycles with mem_addr_sel=1, mem_we=0; WB rd_data_sel=2; total 10 cycles.
- beq with branch_taken=1, then again with 0 → EXEC pc_en=1, pc_sel=1 then 0; rf_en never asserted; 3 cycles each.
- opcode 1111111 → TRAP after DECODE; trap stays 1 for 20 cycles with all other outputs 0; rst pulse → FETCH, trap=0.
- sw with mem_ready=0, rst asserted in the 2nd MEM cycle → mem_req and mem_we drop in the rst cycle; state_o=0 after release; no pc_en is issued.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I core
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_en,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       rf_en,
  output logic [1:0] rd_data_sel,
  output logic [3:0] alu_sel,
  output logic       rs1_pc_sel,
  output logic       rs2_imm_sel,
  output logic       trap,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;

  state_t state_q, state_d;

  logic       is_op, is_opimm, is_load, is_store, is_branch;
  logic       is_jal, is_jalr, is_lui, is_auipc, is_legal;
  logic [3:0] alu_dec;
  logic       rs1_pc_dec, rs2_imm_dec;

  always_comb begin
    is_op     = (opcode == C_OPC_OP);
    is_opimm  = (opcode == C_OPC_OPIMM);
    is_load   = (opcode == C_OPC_LOAD);
    is_store  = (opcode == C_OPC_STORE);
    is_branch = (opcode == C_OPC_BRANCH);
    is_jal    = (opcode == C_OPC_JAL);
    is_jalr   = (opcode == C_OPC_JALR);
    is_lui    = (opcode == C_OPC_LUI);
    is_auipc  = (opcode == C_OPC_AUIPC);
    is_legal  = is_op | is_opimm | is_load | is_store | is_branch |
                is_jal | is_jalr | is_lui | is_auipc;

    alu_dec = 4'd1;
    if (is_lui) begin
      alu_dec = 4'd11;
    end else if (is_op || is_opimm) begin
      case (func3)
        3'd0:    alu_dec = (is_op && func7[5]) ? 4'd2 : 4'd1;
        3'd1:    alu_dec = 4'd3;
        3'd2:    alu_dec = 4'd4;
        3'd3:    alu_dec = 4'd5;
        3'd4:    alu_dec = 4'd6;
        3'd5:    alu_dec = func7[5] ? 4'd8 : 4'd7;
        3'd6:    alu_dec = 4'd9;
        default: alu_dec = 4'd10;
      endcase
    end

    rs1_pc_dec  = is_branch | is_jal | is_auipc;
    rs2_imm_dec = ~is_op;
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    rf_en        = 1'b0;
    rd_data_sel  = 2'd0;
    alu_sel      = 4'd0;
    rs1_pc_sel   = 1'b0;
    rs2_imm_sel  = 1'b0;
    trap         = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = is_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        alu_sel     = alu_dec;
        rs1_pc_sel  = rs1_pc_dec;
        rs2_imm_sel = rs2_imm_dec;
        if (is_branch) begin
          pc_en   = 1'b1;
          pc_sel  = branch_taken;
          state_d = ST_FETCH;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        alu_sel      = alu_dec;
        rs1_pc_sel   = rs1_pc_dec;
        rs2_imm_sel  = rs2_imm_dec;
        if (mem_ready) begin
          if (is_store) begin
            pc_en   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_en       = 1'b1;
        pc_en       = 1'b1;
        rd_data_sel = is_load ? 2'd2 : ((is_jal || is_jalr) ? 2'd3 : 2'd1);
        pc_sel      = is_jal | is_jalr;
        // Jump target comes straight off the ALU, so its operands stay up.
        if (is_jal || is_jalr) begin
          alu_sel     = alu_dec;
          rs1_pc_sel  = rs1_pc_dec;
          rs2_imm_sel = rs2_imm_dec;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Reset kills any in-flight memory request in the same cycle.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_en        = 1'b0;
      pc_en        = 1'b0;
      pc_sel       = 1'b0;
      rf_en        = 1'b0;
      rd_data_sel  = 2'd0;
      alu_sel      = 4'd0;
      rs1_pc_sel   = 1'b0;
      rs2_imm_sel  = 1'b0;
      trap         = 1'b0;
    end
  end

  assign state_o = rst ? 3'd0 : state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_controller: directed self-checking bench for the sequencer
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_sel, rf_en;
  logic [1:0] rd_data_sel;
  logic [3:0] alu_sel;
  logic       rs1_pc_sel, rs2_imm_sel, trap;
  logic [2:0] state_o;

  int total = 0;
  int bad = 0;
  int pc_en_cnt = 0;

  logic [18:0] outs;
  assign outs = {mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_sel, rf_en,
                 rd_data_sel, alu_sel, rs1_pc_sel, rs2_imm_sel, trap, state_o};

  multicycle_controller #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .rf_en(rf_en),
    .rd_data_sel(rd_data_sel), .alu_sel(alu_sel), .rs1_pc_sel(rs1_pc_sel),
    .rs2_imm_sel(rs2_imm_sel), .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Invariants watched on every falling edge.
  always @(negedge clk) begin
    check("inv_rf_we", {31'd0, rf_en & mem_we}, 32'd0);
    if (state_o == 3'd1 || state_o == 3'd2 || state_o == 3'd4)
      check("inv_req_state", {31'd0, mem_req}, 32'd0);
    if (rst || ir_en) begin
      pc_en_cnt = 0;
    end else if (pc_en) begin
      pc_en_cnt++;
      check("inv_pc_once", pc_en_cnt, 32'd1);
    end
  end

  // Runs FETCH (with wait cycles) and DECODE; returns at the start of the next cycle.
  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input int waits);
    opcode = op; func3 = f3; func7 = f7;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      #1;
      check("fetch_wait_state", state_o, 32'd0);
      check("fetch_wait_req", {mem_req, mem_addr_sel, mem_we, ir_en}, 32'b1000);
      nxt;
    end
    mem_ready = 1'b1;
    #1;
    check("fetch_state", state_o, 32'd0);
    check("fetch_req_ir", {mem_req, mem_addr_sel, mem_we, ir_en}, 32'b1001);
    nxt;
    #1;
    check("decode_state", state_o, 32'd1);
    nxt;
  endtask

  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [3:0] exp_alu,
                         input logic exp_a, input logic exp_b);
    fetch_decode(op, f3, f7, 0);
    #1;
    check({tag, "_exec_state"}, state_o, 32'd2);
    check({tag, "_exec_alu"}, alu_sel, exp_alu);
    check({tag, "_exec_ab"}, {rs1_pc_sel, rs2_imm_sel}, {exp_a, exp_b});
    nxt;
    #1;
    check({tag, "_wb_state"}, state_o, 32'd4);
    check({tag, "_wb_ctl"}, {rf_en, rd_data_sel, pc_en, pc_sel}, 32'b10110);
    nxt;
    #1;
    check({tag, "_retire_state"}, state_o, 32'd0);
  endtask

  initial begin
    nxt; nxt;
    #1;
    check("rst_outs", outs, 32'd0);
    rst = 1'b0;

    run_alu("addi", 7'b0010011, 3'd0, 7'b0000000, 4'd1, 1'b0, 1'b1);
    run_alu("sub", 7'b0110011, 3'd0, 7'b0100000, 4'd2, 1'b0, 1'b0);
    run_alu("sra", 7'b0110011, 3'd5, 7'b0100000, 4'd8, 1'b0, 1'b0);
    run_alu("addi_f7", 7'b0010011, 3'd0, 7'b0100000, 4'd1, 1'b0, 1'b1);
    run_alu("xor", 7'b0110011, 3'd4, 7'b0000000, 4'd6, 1'b0, 1'b0);
    run_alu("lui", 7'b0110111, 3'd0, 7'b0000000, 4'd11, 1'b0, 1'b1);
    run_alu("auipc", 7'b0010111, 3'd0, 7'b0000000, 4'd1, 1'b1, 1'b1);

    // lw: 2 fetch waits, 3 data waits, 10 cycles total
    fetch_decode(7'b0000011, 3'd2, 7'd0, 2);
    mem_ready = 1'b0;
    #1;
    check("lw_exec", {state_o, alu_sel, rs2_imm_sel}, {3'd2, 4'd1, 1'b1});
    nxt;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check("lw_mem_state", state_o, 32'd3);
      check("lw_mem_ctl", {mem_req, mem_addr_sel, mem_we, alu_sel}, {3'b110, 4'd1});
      nxt;
    end
    #1;
    check("lw_wb_state", state_o, 32'd4);
    check("lw_wb_ctl", {rf_en, rd_data_sel, pc_en, pc_sel}, 32'b11010);
    nxt;
    #1;
    check("lw_retire_state", state_o, 32'd0);

    // beq taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      fetch_decode(7'b1100011, 3'd0, 7'd0, 0);
      branch_taken = t[0];
      #1;
      check("beq_exec_state", state_o, 32'd2);
      check("beq_exec_pc", {pc_en, pc_sel, rf_en}, {1'b1, t[0], 1'b0});
      check("beq_exec_alu", {alu_sel, rs1_pc_sel, rs2_imm_sel}, {4'd1, 2'b11});
      nxt;
      #1;
      check("beq_retire_state", state_o, 32'd0);
    end
    branch_taken = 1'b0;

    // jal: link value in WB, PC from ALU
    fetch_decode(7'b1101111, 3'd0, 7'd0, 0);
    #1;
    check("jal_exec", {state_o, pc_en, alu_sel, rs1_pc_sel, rs2_imm_sel}, {3'd2, 1'b0, 4'd1, 2'b11});
    nxt;
    #1;
    check("jal_wb_ctl", {rf_en, rd_data_sel, pc_en, pc_sel}, 32'b11111);
    check("jal_wb_alu", {alu_sel, rs1_pc_sel, rs2_imm_sel}, {4'd1, 2'b11});
    nxt;

    // illegal opcode traps and stays trapped
    fetch_decode(7'b1111111, 3'd0, 7'd0, 0);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("trap_outs", outs, 32'hD);
      nxt;
    end
    rst = 1'b1;
    #1;
    check("trap_rst_outs", outs, 32'd0);
    nxt;
    rst = 1'b0;
    #1;
    check("trap_release", {state_o, trap, mem_req}, {3'd0, 1'b0, 1'b1});

    // sw with stalled memory, aborted by reset in its 2nd MEM cycle
    fetch_decode(7'b0100011, 3'd2, 7'd0, 0);
    mem_ready = 1'b0;
    #1;
    check("sw_exec", {state_o, pc_en, rs2_imm_sel}, {3'd2, 1'b0, 1'b1});
    nxt;
    #1;
    check("sw_mem1", {state_o, mem_req, mem_we, mem_addr_sel, pc_en}, {3'd3, 4'b1110});
    nxt;
    rst = 1'b1;
    #1;
    check("sw_rst_cycle", {state_o, mem_req, mem_we, pc_en}, 32'd0);
    nxt;
    rst = 1'b0;
    #1;
    check("sw_after_rst", {state_o, mem_req, mem_we, pc_en}, {3'd0, 3'b100});
    nxt;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
